// File: rtl/sync_debounce_edge.sv
// Multi-channel input conditioner for slow asynchronous level inputs.
// Each channel: STAGES-flop synchroniser -> debounce filter -> registered
// rise/fall pulses. The filtered level and both pulse vectors are registered,
// so there is no combinational path from a_i to any output.
module sync_debounce_edge #(
    parameter int unsigned      WIDTH     = 4,
    parameter int unsigned      STAGES    = 2,
    parameter int unsigned      DEBOUNCE  = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] a_i,
    output logic [WIDTH-1:0] z_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    // Counter is wide enough to hold DEBOUNCE-1; DEBOUNCE=1 still gets one bit
    // that simply never leaves zero.
    localparam int unsigned      CNT_W   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

    logic [WIDTH-1:0] sync_r [STAGES];
    logic [CNT_W-1:0] cnt_r [WIDTH];
    logic [CNT_W-1:0] cnt_nxt_s [WIDTH];
    logic [WIDTH-1:0] z_r;
    logic [WIDTH-1:0] rise_r;
    logic [WIDTH-1:0] fall_r;
    logic [WIDTH-1:0] z_nxt_s;
    logic [WIDTH-1:0] rise_nxt_s;
    logic [WIDTH-1:0] fall_nxt_s;
    logic [WIDTH-1:0] s_s;

    assign s_s = sync_r[STAGES-1];

    // Synchroniser shift chain; clear reloads it so a pending edge is forgotten.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < STAGES; k++) begin
                sync_r[k] <= RESET_VAL;
            end
        end else if (clear_i) begin
            for (int k = 0; k < STAGES; k++) begin
                sync_r[k] <= RESET_VAL;
            end
        end else begin
            sync_r[0] <= a_i;
            for (int k = 1; k < STAGES; k++) begin
                sync_r[k] <= sync_r[k-1];
            end
        end
    end

    // Per-channel filter decision: any agreement between s and z restarts the
    // count; the flip (and its pulse) happens when the count saturates.
    always_comb begin
        z_nxt_s    = z_r;
        rise_nxt_s = {WIDTH{1'b0}};
        fall_nxt_s = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt_s[i] = cnt_r[i];
            if (s_s[i] == z_r[i]) begin
                cnt_nxt_s[i] = {CNT_W{1'b0}};
            end else if (cnt_r[i] == CNT_MAX) begin
                cnt_nxt_s[i]  = {CNT_W{1'b0}};
                z_nxt_s[i]    = s_s[i];
                rise_nxt_s[i] = s_s[i];
                fall_nxt_s[i] = ~s_s[i];
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + CNT_W'(1);
            end
        end
    end

    // Filter state and edge pulses; clear behaves exactly like reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= {CNT_W{1'b0}};
            end
            z_r    <= RESET_VAL;
            rise_r <= {WIDTH{1'b0}};
            fall_r <= {WIDTH{1'b0}};
        end else if (clear_i) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= {CNT_W{1'b0}};
            end
            z_r    <= RESET_VAL;
            rise_r <= {WIDTH{1'b0}};
            fall_r <= {WIDTH{1'b0}};
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
            z_r    <= z_nxt_s;
            rise_r <= rise_nxt_s;
            fall_r <= fall_nxt_s;
        end
    end

    assign z_o    = z_r;
    assign rise_o = rise_r;
    assign fall_o = fall_r;

endmodule
